// File: rtl/axi_write_mngr_p_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_mngr_p_if
// Purpose  : Bus request/grant plus AXI AW/W/B channels of the write manager
// Revision : 1.0
// ============================================================================
interface axi_write_mngr_p_if #(
    parameter int DATA_W = 32
);
    logic                  req_rq;
    logic                  gnt_rq;
    logic                  awvalid;
    logic                  awready;
    logic [3:0]            awid;
    logic [31:0]           awaddr;
    logic [7:0]            awlen;
    logic [5:0]            awatop;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [3:0]            bid;
    logic [1:0]            bresp;

    modport master (
        output req_rq, input gnt_rq,
        output awvalid, input awready, output awid, output awaddr, output awlen, output awatop,
        output wvalid, input wready, output wdata, output wstrb, output wlast,
        input bvalid, output bready, input bid, input bresp
    );

    modport slave (
        input req_rq, output gnt_rq,
        input awvalid, output awready, input awid, input awaddr, input awlen, input awatop,
        input wvalid, output wready, input wdata, input wstrb, input wlast,
        output bvalid, input bready, output bid, output bresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_write_mngr_p.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_mngr_p
// Purpose  : Issues one AXI write burst at a time and tracks its B responses
// Revision : 1.0
// ============================================================================
module axi_write_mngr_p #(
    parameter logic [1:0] M_ID   = 2'b00,
    parameter int         DATA_W = 32,
    parameter int         BEATS  = 4,
    parameter int         OUTST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_write_mngr_p_if.master         bus,
    input  logic                       wstart_rq,
    input  logic [31:0]                win_addr,
    input  logic [BEATS*DATA_W-1:0]    in_wdata,
    input  logic [BEATS*DATA_W/8-1:0]  in_wstrb,
    output logic                       wbusy,
    output logic                       finish_wresp,
    output logic [3:0]                 finish_id,
    output logic                       finish_err,
    output logic                       stray_b,
    output logic [2:0]                 outst_cnt
);
    localparam int             STRB_W    = DATA_W / 8;
    localparam int             BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int             IW        = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
    localparam logic [2:0]     OUTST_MAX = 3'(OUTST);
    localparam logic [7:0]     AW_LEN    = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                seq_q, seq_d;
    logic [3:0]                id_q, id_d;
    logic [31:0]               addr_q, addr_d;
    logic [BEATS*DATA_W-1:0]   data_q, data_d;
    logic [BEATS*STRB_W-1:0]   strb_q, strb_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [OUTST-1:0]          vld_q, vld_d;
    logic [OUTST-1:0][3:0]     tid_q, tid_d;
    logic                      fin_q, fin_d;
    logic                      ferr_q, ferr_d;
    logic                      stray_q, stray_d;
    logic [3:0]                fid_q, fid_d;

    logic                      w_accept;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_last;
    logic                      w_b_hs;
    logic                      w_hit;
    logic                      w_free_ok;
    logic [IW-1:0]             w_hit_idx;
    logic [IW-1:0]             w_free_idx;
    logic [2:0]                w_cnt;
    logic [DATA_W-1:0]         w_wdata;
    logic [STRB_W-1:0]         w_wstrb;

    always_comb begin
        w_cnt = 3'd0;
        for (int i = 0; i < OUTST; i++) begin
            w_cnt = w_cnt + 3'(vld_q[i]);
        end
    end

    assign wbusy     = (state_q != ST_IDLE) | (w_cnt == OUTST_MAX);
    assign w_accept  = wstart_rq & ~wbusy;
    assign w_aw_hs   = (state_q == ST_ADDR) & bus.awready;
    assign w_w_hs    = (state_q == ST_DATA) & bus.wready;
    assign w_last    = (beat_q == LAST_BEAT);
    assign w_b_hs    = bus.bvalid & bus.bready;

    // Select the current beat's slice without a variable part-select
    always_comb begin
        w_wdata = '0;
        w_wstrb = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BW'(k)) begin
                w_wdata = data_q[k*DATA_W +: DATA_W];
                w_wstrb = strb_q[k*STRB_W +: STRB_W];
            end
        end
    end

    assign bus.req_rq  = (state_q != ST_IDLE);
    assign bus.awvalid = (state_q == ST_ADDR);
    assign bus.awid    = id_q;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = AW_LEN;
    assign bus.awatop  = 6'd0;
    assign bus.wvalid  = (state_q == ST_DATA);
    assign bus.wdata   = w_wdata;
    assign bus.wstrb   = w_wstrb;
    assign bus.wlast   = (state_q == ST_DATA) & w_last;
    assign bus.bready  = (w_cnt != 3'd0);

    assign finish_wresp = fin_q;
    assign finish_id    = fid_q;
    assign finish_err   = ferr_q;
    assign stray_b      = stray_q;
    assign outst_cnt    = w_cnt;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        id_d    = id_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_REQ;
                    id_d    = {M_ID, seq_q};
                    seq_d   = seq_q + 2'd1;
                    addr_d  = win_addr;
                    data_d  = in_wdata;
                    strb_d  = in_wstrb;
                    beat_d  = '0;
                end
            end
            ST_REQ: begin
                if (bus.gnt_rq) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_aw_hs) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_w_hs) begin
                    if (w_last) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lookups use the pre-edge table so a same-cycle free never feeds the allocation
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_ok  = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < OUTST; i++) begin
            if (!w_hit && vld_q[i] && (tid_q[i] == bus.bid)) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!w_free_ok && !vld_q[i]) begin
                w_free_ok  = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        vld_d   = vld_q;
        tid_d   = tid_q;
        fin_d   = 1'b0;
        ferr_d  = 1'b0;
        stray_d = 1'b0;
        fid_d   = fid_q;
        if (w_b_hs) begin
            if (w_hit) begin
                vld_d[w_hit_idx] = 1'b0;
                fin_d            = 1'b1;
                fid_d            = bus.bid;
                ferr_d           = (bus.bresp != 2'b00);
            end else begin
                stray_d          = 1'b1;
            end
        end
        if (w_aw_hs && w_free_ok) begin
            vld_d[w_free_idx] = 1'b1;
            tid_d[w_free_idx] = id_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seq_q   <= 2'd0;
            id_q    <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= '0;
            strb_q  <= '0;
            beat_q  <= '0;
            vld_q   <= '0;
            tid_q   <= '0;
            fin_q   <= 1'b0;
            ferr_q  <= 1'b0;
            stray_q <= 1'b0;
            fid_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            tid_q   <= tid_d;
            fin_q   <= fin_d;
            ferr_q  <= ferr_d;
            stray_q <= stray_d;
            fid_q   <= fid_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_write_mngr_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_write_mngr_p
// Purpose  : Directed bench for axi_write_mngr_p with a transaction-level model
// Revision : 1.0
// ============================================================================
module tb_axi_write_mngr_p;
    localparam logic [1:0] M_ID   = 2'b00;
    localparam int         DATA_W = 32;
    localparam int         BEATS  = 4;
    localparam int         OUTST  = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      wstart_rq = 1'b0;
    logic [31:0]               win_addr = 32'd0;
    logic [BEATS*DATA_W-1:0]   in_wdata = '0;
    logic [BEATS*DATA_W/8-1:0] in_wstrb = '0;
    logic                      wbusy;
    logic                      finish_wresp;
    logic [3:0]                finish_id;
    logic                      finish_err;
    logic                      stray_b;
    logic [2:0]                outst_cnt;

    axi_write_mngr_p_if #(.DATA_W(DATA_W)) bus();

    axi_write_mngr_p #(
        .M_ID(M_ID), .DATA_W(DATA_W), .BEATS(BEATS), .OUTST(OUTST)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .wstart_rq(wstart_rq), .win_addr(win_addr), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
        .wbusy(wbusy), .finish_wresp(finish_wresp), .finish_id(finish_id),
        .finish_err(finish_err), .stray_b(stray_b), .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: one burst in flight plus a list of un-responded ids
    bit          m_inflight, m_granted, m_awdone, m_fin, m_ferr, m_stray;
    int          m_beat, m_idx;
    logic [1:0]  m_seq;
    logic [3:0]  m_id, m_fid;
    logic [31:0] m_addr;
    logic [31:0] m_data [BEATS];
    logic [3:0]  m_strb [BEATS];
    logic [3:0]  m_outq [$];
    bit          e_busy, e_bready, e_aw, e_w;

    logic [31:0] aw_addr_log [$];
    logic [3:0]  aw_id_log [$];
    logic [31:0] beat_log [$];
    bit          last_log [$];
    logic [4:0]  fin_log [$];
    int          stray_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_rq", bus.req_rq, 1'b0);
            chk("rst_awvalid", bus.awvalid, 1'b0);
            chk("rst_wvalid", bus.wvalid, 1'b0);
            chk("rst_wlast", bus.wlast, 1'b0);
            chk("rst_bready", bus.bready, 1'b0);
            chk("rst_finish", finish_wresp, 1'b0);
            chk("rst_finish_err", finish_err, 1'b0);
            chk("rst_stray", stray_b, 1'b0);
            chk("rst_awid", bus.awid, 4'd0);
            chk("rst_awaddr", bus.awaddr, 32'd0);
            chk("rst_wdata", bus.wdata, 32'd0);
            chk("rst_wstrb", bus.wstrb, 4'd0);
            chk("rst_finish_id", finish_id, 4'd0);
            chk("rst_outst_cnt", outst_cnt, 3'd0);
            chk("rst_wbusy", wbusy, 1'b0);
            m_inflight = 0; m_granted = 0; m_awdone = 0; m_beat = 0; m_seq = 2'd0;
            m_fin = 0; m_ferr = 0; m_stray = 0;
            m_outq.delete();
        end else begin
            e_busy   = m_inflight || (m_outq.size() == OUTST);
            e_bready = (m_outq.size() != 0);
            e_aw     = m_inflight && m_granted && !m_awdone;
            e_w      = m_inflight && m_awdone;
            chk("req_rq", bus.req_rq, m_inflight);
            chk("awvalid", bus.awvalid, e_aw);
            chk("wvalid", bus.wvalid, e_w);
            chk("wbusy", wbusy, e_busy);
            chk("outst_cnt", outst_cnt, m_outq.size());
            chk("bready", bus.bready, e_bready);
            chk("awlen", bus.awlen, BEATS - 1);
            chk("awatop", bus.awatop, 6'd0);
            chk("finish_wresp", finish_wresp, m_fin);
            chk("finish_err", finish_err, m_ferr);
            chk("stray_b", stray_b, m_stray);
            if (m_fin) chk("finish_id", finish_id, m_fid);
            if (e_aw) begin
                chk("awaddr", bus.awaddr, m_addr);
                chk("awid", bus.awid, m_id);
            end
            if (e_w) begin
                chk("wdata", bus.wdata, m_data[m_beat]);
                chk("wstrb", bus.wstrb, m_strb[m_beat]);
                chk("wlast", bus.wlast, m_beat == BEATS - 1);
            end else begin
                chk("wlast_idle", bus.wlast, 1'b0);
            end

            if (bus.awvalid && bus.awready) begin
                aw_addr_log.push_back(bus.awaddr);
                aw_id_log.push_back(bus.awid);
            end
            if (bus.wvalid && bus.wready) begin
                beat_log.push_back(bus.wdata);
                last_log.push_back(bus.wlast);
            end
            if (finish_wresp) fin_log.push_back({finish_id, finish_err});
            if (stray_b) stray_seen++;

            // Effects of the coming clock edge
            m_fin = 0; m_ferr = 0; m_stray = 0;
            if (bus.bvalid && e_bready) begin
                m_idx = -1;
                foreach (m_outq[i]) if (m_idx < 0 && m_outq[i] == bus.bid) m_idx = i;
                if (m_idx >= 0) begin
                    m_outq.delete(m_idx);
                    m_fin  = 1;
                    m_fid  = bus.bid;
                    m_ferr = (bus.bresp != 2'b00);
                end else begin
                    m_stray = 1;
                end
            end
            if (e_aw && bus.awready) begin
                m_awdone = 1;
                m_outq.push_back(m_id);
            end
            if (e_w && bus.wready) begin
                if (m_beat == BEATS - 1) m_inflight = 0;
                else m_beat++;
            end
            if (m_inflight && !m_granted && bus.gnt_rq) m_granted = 1;
            if (wstart_rq && !e_busy) begin
                m_inflight = 1; m_granted = 0; m_awdone = 0; m_beat = 0;
                m_addr = win_addr;
                m_id   = {M_ID, m_seq};
                m_seq  = m_seq + 2'd1;
                for (int k = 0; k < BEATS; k++) begin
                    m_data[k] = in_wdata[k*DATA_W +: DATA_W];
                    m_strb[k] = in_wstrb[k*4 +: 4];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        for (int c = 0; c < 32 && wbusy; c++) tick();
        chk("accept_ready", wbusy, 1'b0);
        wstart_rq = 1'b1; win_addr = a; in_wdata = d; in_wstrb = s;
        tick();
        wstart_rq = 1'b0;
    endtask

    task automatic run_data(input bit bp);
        int  k = 0;
        bit  done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.wready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (bus.wvalid) k++;
            tick();
            if (!bus.req_rq) done = 1;
        end
        bus.wready = 1'b0;
        chk("burst_done", done, 1'b1);
    endtask

    task automatic burst(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s, input bit bp);
        do_accept(a, d, s);
        tick(); tick();
        bus.gnt_rq = 1'b1; bus.awready = 1'b1;
        run_data(bp);
        bus.gnt_rq = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
        bus.bvalid = 1'b1; bus.bid = id; bus.bresp = resp;
        tick();
        bus.bvalid = 1'b0;
        tick();
    endtask

    logic [31:0] exp_beats [8] = '{32'h11, 32'h22, 32'h33, 32'h44,
                                   32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003, 32'hA4A4_0004};
    int base, nfin;

    initial begin
        bus.gnt_rq = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_wbusy", wbusy, 1'b0);
        chk("idle_outst", outst_cnt, 3'd0);

        // Single burst, then its response
        burst(32'h1000, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, 1'b0);
        send_b(4'h0, 2'b00);
        chk("t1_aw_count", aw_addr_log.size(), 1);
        if (aw_addr_log.size() >= 1) begin
            chk("t1_awaddr", aw_addr_log[0], 32'h1000);
            chk("t1_awid", aw_id_log[0], 4'h0);
        end
        chk("t1_fin_count", fin_log.size(), 1);
        if (fin_log.size() >= 1) chk("t1_fin", fin_log[0], {4'h0, 1'b0});

        // Backpressured data phase
        burst(32'h2000, {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001}, 16'h8C3F, 1'b1);
        chk("beat_count", beat_log.size(), 8);
        if (beat_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("beat_data", beat_log[i], exp_beats[i]);
                chk("beat_last", last_log[i], (i % 4) == 3);
            end
        end

        // Outstanding limit reached, extra request ignored
        burst(32'h3000, {4{32'h3333_0000}}, 16'hFFFF, 1'b0);
        chk("lim_outst", outst_cnt, 3'd2);
        chk("lim_wbusy", wbusy, 1'b1);
        wstart_rq = 1'b1; win_addr = 32'h4000;
        repeat (3) tick();
        wstart_rq = 1'b0;
        tick();
        chk("lim_no_req", bus.req_rq, 1'b0);
        chk("lim_aw_count", aw_addr_log.size(), 3);

        // Out-of-order responses
        send_b(4'h2, 2'b10);
        chk("ooo_outst", outst_cnt, 3'd1);
        chk("ooo_wbusy", wbusy, 1'b0);
        send_b(4'h1, 2'b00);
        chk("ooo_fin_count", fin_log.size(), 3);
        if (fin_log.size() >= 3) begin
            chk("ooo_fin_a", fin_log[1], {4'h2, 1'b1});
            chk("ooo_fin_b", fin_log[2], {4'h1, 1'b0});
        end

        // Sequence wrap and stray response
        burst(32'h5000, {4{32'h5555_0000}}, 16'hFFFF, 1'b0);
        send_b(4'h3, 2'b00);
        burst(32'h6000, {4{32'h6666_0000}}, 16'hFFFF, 1'b0);
        if (aw_id_log.size() >= 5) chk("wrap_awid", aw_id_log[4], 4'h0);
        send_b(4'h7, 2'b00);
        chk("stray_once", stray_seen, 1);
        chk("stray_outst", outst_cnt, 3'd1);
        chk("stray_fin_count", fin_log.size(), 4);

        // AW allocation and B free on the same edge
        do_accept(32'h7000, {4{32'h7777_0000}}, 16'hFFFF);
        tick(); tick();
        bus.gnt_rq = 1'b1; bus.awready = 1'b0;
        for (int c = 0; c < 32 && !bus.awvalid; c++) tick();
        chk("same_aw_seen", bus.awvalid, 1'b1);
        bus.awready = 1'b1; bus.bvalid = 1'b1; bus.bid = 4'h0; bus.bresp = 2'b00;
        tick();
        bus.bvalid = 1'b0;
        chk("same_outst", outst_cnt, 3'd1);
        run_data(1'b0);
        bus.gnt_rq = 1'b0;
        send_b(4'h1, 2'b00);
        chk("same_outst_end", outst_cnt, 3'd0);

        // Reset in the middle of a burst
        do_accept(32'h8000, {4{32'h8888_0000}}, 16'hFFFF);
        tick(); tick();
        bus.gnt_rq = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
        base = beat_log.size();
        for (int c = 0; c < 32 && beat_log.size() < base + 2; c++) tick();
        chk("rst_two_beats", beat_log.size(), base + 2);
        rst = 1'b1; bus.wready = 1'b0; bus.gnt_rq = 1'b0;
        #1;
        chk("rst_now_wvalid", bus.wvalid, 1'b0);
        chk("rst_now_outst", outst_cnt, 3'd0);
        tick();
        rst = 1'b0;
        nfin = fin_log.size();
        tick();
        burst(32'h9000, {4{32'h9999_0000}}, 16'hFFFF, 1'b0);
        if (aw_id_log.size() >= 1) chk("post_rst_awid", aw_id_log[aw_id_log.size()-1], 4'h0);
        send_b(4'h0, 2'b00);
        chk("post_rst_fin_count", fin_log.size(), nfin + 1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
